// File: rtl/sha3_scan_pkg.sv
// Shared constants and types for the SHA3 scan front end:
// frame geometry and the launch sequencer states.
package sha3_scan_pkg;

   localparam int TEMPLATE_WORDS = 24;
   localparam int FRAME_WORDS = TEMPLATE_WORDS + 2;

   typedef logic [TEMPLATE_WORDS-1:0][31:0] template_t;

   typedef enum logic [1:0] {
      IDLE,
      ACK,
      RUN
   } launch_state_t;

endpackage

// File: rtl/sha3_frame_assembler.sv
// Collects one work frame (threshold + template) from the word stream
// into a shadow buffer; malformed frames are dropped with an error pulse.
module sha3_frame_assembler #(
   parameter int TEMPLATE_WORDS = sha3_scan_pkg::TEMPLATE_WORDS
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid_i,
   input  logic [31:0]                    in_data_i,
   input  logic                           in_last_i,
   output logic                           in_ready_o,
   input  logic                           take_i,
   output logic                           full_o,
   output logic [63:0]                    thr_o,
   output logic [TEMPLATE_WORDS*32-1:0]   tmpl_o,
   output logic                           frame_error_o
);
   import sha3_scan_pkg::*;

   localparam int FW = TEMPLATE_WORDS + 2;
   localparam int CW = $clog2(FW);
   localparam int TIW = $clog2(TEMPLATE_WORDS);
   localparam logic [CW-1:0] LAST_IDX = CW'(FW - 1);

   logic [CW-1:0]                     wcnt_q, wcnt_d;
   logic                              full_q, full_d;
   logic                              rdy_q;
   logic                              err_q, err_d;
   logic [63:0]                       thr_q, thr_d;
   logic [TEMPLATE_WORDS-1:0][31:0]   tmpl_q, tmpl_d;
   logic [TIW-1:0]                    tidx;
   logic                              xfer;

   assign xfer = in_valid_i && rdy_q;
   assign tidx = TIW'(wcnt_q - CW'(2));

   always_comb begin
      wcnt_d = wcnt_q;
      full_d = full_q;
      thr_d  = thr_q;
      tmpl_d = tmpl_q;
      err_d  = 1'b0;
      if (take_i) full_d = 1'b0;
      if (xfer) begin
         if (wcnt_q == '0) thr_d[31:0] = in_data_i;
         else if (wcnt_q == CW'(1)) thr_d[63:32] = in_data_i;
         else tmpl_d[tidx] = in_data_i;
         // Only a last-flagged word at the final index completes a frame
         if (wcnt_q == LAST_IDX) begin
            wcnt_d = '0;
            full_d = in_last_i;
            err_d  = !in_last_i;
         end else if (in_last_i) begin
            wcnt_d = '0;
            err_d  = 1'b1;
         end else begin
            wcnt_d = wcnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q <= '0;
         full_q <= 1'b0;
         rdy_q  <= 1'b0;
         err_q  <= 1'b0;
         thr_q  <= '0;
         tmpl_q <= '0;
      end else begin
         wcnt_q <= wcnt_d;
         full_q <= full_d;
         rdy_q  <= !full_d;
         err_q  <= err_d;
         thr_q  <= thr_d;
         tmpl_q <= tmpl_d;
      end
   end

   assign in_ready_o    = rdy_q;
   assign full_o        = full_q;
   assign thr_o         = thr_q;
   assign tmpl_o        = tmpl_q;
   assign frame_error_o = err_q;

endmodule

// File: rtl/sha3_work_loader.sv
// Double-buffered work feeder for the packed-by-6 SHA3 scanner:
// launches a queued frame whenever the scanner reports idle.
module sha3_work_loader #(
   parameter int TEMPLATE_WORDS = sha3_scan_pkg::TEMPLATE_WORDS,
   parameter int LAUNCH_CNT_W = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           in_valid,
   input  logic [31:0]                    in_data,
   input  logic                           in_last,
   output logic                           in_ready,
   input  logic                           scanner_ready,
   output logic                           start,
   output logic [63:0]                    threshold,
   output logic [32*TEMPLATE_WORDS-1:0]   blockTemplate,
   output logic                           oframe_error,
   output logic                           opending,
   output logic                           orunning,
   output logic [LAUNCH_CNT_W-1:0]        olaunches
);
   import sha3_scan_pkg::*;

   launch_state_t                  state_q, state_d;
   logic                           launch;
   logic                           sh_full;
   logic [63:0]                    sh_thr;
   logic [32*TEMPLATE_WORDS-1:0]   sh_tmpl;
   logic                           start_q;
   logic [63:0]                    thr_q;
   logic [32*TEMPLATE_WORDS-1:0]   tmpl_q;
   logic [LAUNCH_CNT_W-1:0]        launches_q;

   sha3_frame_assembler #(
      .TEMPLATE_WORDS(TEMPLATE_WORDS)
   ) u_asm (
      .clk           (clk),
      .rst           (rst),
      .in_valid_i    (in_valid),
      .in_data_i     (in_data),
      .in_last_i     (in_last),
      .in_ready_o    (in_ready),
      .take_i        (launch),
      .full_o        (sh_full),
      .thr_o         (sh_thr),
      .tmpl_o        (sh_tmpl),
      .frame_error_o (oframe_error)
   );

   // ACK waits for the scanner to drop oready, RUN for it to return
   always_comb begin
      state_d = state_q;
      launch  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (sh_full && scanner_ready) begin
               launch  = 1'b1;
               state_d = ACK;
            end
         end
         ACK:     if (!scanner_ready) state_d = RUN;
         RUN:     if (scanner_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         start_q    <= 1'b0;
         thr_q      <= '0;
         tmpl_q     <= '0;
         launches_q <= '0;
      end else begin
         state_q <= state_d;
         start_q <= launch;
         if (launch) begin
            thr_q      <= sh_thr;
            tmpl_q     <= sh_tmpl;
            launches_q <= launches_q + LAUNCH_CNT_W'(1);
         end
      end
   end

   assign start         = start_q;
   assign threshold     = thr_q;
   assign blockTemplate = tmpl_q;
   assign opending      = sh_full;
   assign orunning      = (state_q != IDLE);
   assign olaunches     = launches_q;

endmodule

// File: tb/tb_sha3_work_loader.sv
// Randomized bench for sha3_work_loader with a frame-level reference
// model and a small scanner emulation driving scanner_ready.
module tb_sha3_work_loader;

   localparam int TW = 24;
   localparam int FW = TW + 2;
   localparam int LW = 16;

   typedef logic [31:0] frame_t [FW];
   typedef struct {
      logic [31:0] data;
      logic        last;
   } tx_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic [31:0]      in_data;
   logic             in_last;
   logic             in_ready;
   logic             scanner_ready;
   logic             start;
   logic [63:0]      threshold;
   logic [TW*32-1:0] blockTemplate;
   logic             oframe_error;
   logic             opending;
   logic             orunning;
   logic [LW-1:0]    olaunches;

   always #5 clk = ~clk;

   sha3_work_loader #(
      .TEMPLATE_WORDS(TW),
      .LAUNCH_CNT_W(LW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_data       (in_data),
      .in_last       (in_last),
      .in_ready      (in_ready),
      .scanner_ready (scanner_ready),
      .start         (start),
      .threshold     (threshold),
      .blockTemplate (blockTemplate),
      .oframe_error  (oframe_error),
      .opending      (opending),
      .orunning      (orunning),
      .olaunches     (olaunches)
   );

   int checks = 0;
   int errors = 0;

   tx_t         tx_q[$];
   int unsigned vprob = 100;
   int          scan_len = 3;
   int          sc_cnt = 0;
   int          edge_n = 0;
   int          starts_seen = 0;
   int          errs_seen = 0;
   int          words_acc = 0;
   int          acc_while_full = 0;
   int          start_edge = -1;
   int          last_acc_edge = -1;
   int          idle_edge = -1;
   int          div_cnt = 0;

   // Reference model: frame words collected so far, one pending frame,
   // the launched frame, and where the scanner handshake stands.
   logic [31:0]   m_col[$];
   bit            m_pend;
   bit            m_busy;
   bit            m_dropped;
   bit            m_ready;
   bit            m_start;
   bit            m_err;
   frame_t        m_pw;
   frame_t        m_act;
   logic [LW-1:0] m_launches;

   function automatic logic [63:0] thr_of(input frame_t f);
      return {f[1], f[0]};
   endfunction

   function automatic logic [TW*32-1:0] tmpl_of(input frame_t f);
      logic [TW*32-1:0] v;
      v = '0;
      for (int i = 0; i < TW; i++) v[32*i +: 32] = f[i+2];
      return v;
   endfunction

   task automatic rand_frame(output frame_t f);
      for (int i = 0; i < FW; i++) f[i] = $urandom;
   endtask

   task automatic push_frame(input frame_t f, input int n, input int last_at);
      tx_t t;
      for (int i = 0; i < n; i++) begin
         t.data = f[i];
         t.last = (i == last_at);
         tx_q.push_back(t);
      end
   endtask

   task automatic model_reset();
      m_col.delete();
      m_pend = 0;
      m_busy = 0;
      m_dropped = 0;
      m_ready = 0;
      m_start = 0;
      m_err = 0;
      m_launches = '0;
      for (int i = 0; i < FW; i++) begin
         m_pw[i] = '0;
         m_act[i] = '0;
      end
   endtask

   task automatic model_step();
      bit acc;
      bit launch;
      if (rst) begin
         model_reset();
         return;
      end
      acc = in_valid && m_ready;
      launch = !m_busy && m_pend && scanner_ready;
      m_start = launch;
      m_err = 0;
      if (launch) begin
         m_act = m_pw;
         m_pend = 0;
         m_launches = m_launches + 1'b1;
         m_busy = 1;
         m_dropped = 0;
      end else if (m_busy) begin
         if (!m_dropped) begin
            if (!scanner_ready) m_dropped = 1;
         end else if (scanner_ready) begin
            m_busy = 0;
         end
      end
      if (acc) begin
         m_col.push_back(in_data);
         if (m_col.size() == FW) begin
            if (in_last) begin
               m_pend = 1;
               for (int i = 0; i < FW; i++) m_pw[i] = m_col[i];
            end else begin
               m_err = 1;
            end
            m_col.delete();
         end else if (in_last) begin
            m_err = 1;
            m_col.delete();
         end
      end
      m_ready = !m_pend;
   endtask

   task automatic tick();
      bit hs;
      bit pend_b;
      bit run_b;
      if (!rst && tx_q.size() > 0 && $urandom_range(99) < vprob) begin
         in_valid = 1'b1;
         in_data = tx_q[0].data;
         in_last = tx_q[0].last;
      end else begin
         in_valid = 1'b0;
         in_data = $urandom;
         in_last = 1'($urandom_range(1));
      end
      hs = in_valid && in_ready;
      pend_b = (opending === 1'b1);
      run_b = (orunning === 1'b1);
      model_step();
      @(posedge clk);
      #1;
      edge_n++;
      if (hs && !rst) begin
         if (pend_b) acc_while_full++;
         void'(tx_q.pop_front());
         words_acc++;
         if (in_last) last_acc_edge = edge_n;
      end
      if (start === 1'b1) begin
         starts_seen++;
         start_edge = edge_n;
      end
      if (oframe_error === 1'b1) errs_seen++;
      if (run_b && orunning === 1'b0) idle_edge = edge_n;
      if (start !== m_start || in_ready !== m_ready || opending !== m_pend ||
          orunning !== m_busy || oframe_error !== m_err ||
          olaunches !== m_launches || threshold !== thr_of(m_act) ||
          blockTemplate !== tmpl_of(m_act)) begin
         div_cnt++;
         if (div_cnt <= 5)
            $display("diverge edge %0d: start %b/%b rdy %b/%b pend %b/%b run %b/%b err %b/%b n %0d/%0d",
                     edge_n, start, m_start, in_ready, m_ready, opending, m_pend,
                     orunning, m_busy, oframe_error, m_err, olaunches, m_launches);
      end
      if (start === 1'b1) begin
         scanner_ready = 1'b0;
         sc_cnt = scan_len;
      end else if (sc_cnt > 0) begin
         sc_cnt--;
         if (sc_cnt == 0) scanner_ready = 1'b1;
      end
   endtask

   task automatic clear_obs();
      starts_seen = 0;
      errs_seen = 0;
      words_acc = 0;
      acc_while_full = 0;
   endtask

   task automatic do_reset();
      int k;
      tx_q.delete();
      k = 0;
      while (sc_cnt > 0 && k < 500) begin
         tick();
         k++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      clear_obs();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic run_until_starts(input int n, input int budget, output bit ok);
      int k;
      k = 0;
      while (starts_seen < n && k < budget) begin
         tick();
         k++;
      end
      ok = (starts_seen >= n);
   endtask

   task automatic run_until_drained(input int budget, output bit ok);
      int k;
      k = 0;
      while (tx_q.size() > 0 && k < budget) begin
         tick();
         k++;
      end
      ok = (tx_q.size() == 0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++;
      if ({start, oframe_error, opending, orunning, in_ready} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 00000",
                  {start, oframe_error, opending, orunning, in_ready});
      end
      checks++;
      if (threshold !== 64'd0) begin
         errors++;
         $display("FAIL reset_threshold got %h want 0", threshold);
      end
      checks++;
      if (blockTemplate !== '0) begin
         errors++;
         $display("FAIL reset_template got nonzero want 0");
      end
      checks++;
      if (olaunches !== 16'd0) begin
         errors++;
         $display("FAIL reset_launches got %0d want 0", olaunches);
      end
      rst = 1'b0;
      tick();
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got %b want 1", in_ready);
      end
      clear_obs();
   endtask

   task automatic test_single_frame();
      frame_t f;
      bit ok;
      int d0;
      do_reset();
      d0 = div_cnt;
      vprob = 100;
      scan_len = 4;
      f[0] = 32'hFFFF_FFFF;
      f[1] = 32'h0000_00FF;
      for (int i = 0; i < TW; i++) f[i+2] = i;
      push_frame(f, FW, FW - 1);
      run_until_starts(1, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL single_timeout got %0d starts want 1", starts_seen);
      end
      checks++;
      if (start_edge - last_acc_edge !== 1) begin
         errors++;
         $display("FAIL single_latency got %0d edges want 1", start_edge - last_acc_edge);
      end
      checks++;
      if (threshold !== 64'h0000_00FF_FFFF_FFFF) begin
         errors++;
         $display("FAIL single_threshold got %h want 000000ffffffffff", threshold);
      end
      checks++;
      if (blockTemplate !== tmpl_of(f)) begin
         errors++;
         $display("FAIL single_template got %h want %h", blockTemplate[63:0], tmpl_of(f) >> 0);
      end
      checks++;
      if (olaunches !== 16'd1) begin
         errors++;
         $display("FAIL single_launches got %0d want 1", olaunches);
      end
      run(10);
      checks++;
      if (starts_seen !== 1) begin
         errors++;
         $display("FAIL single_start_count got %0d want 1", starts_seen);
      end
      checks++;
      if (div_cnt !== d0) begin
         errors++;
         $display("FAIL single_model got %0d divergences want 0", div_cnt - d0);
      end
   endtask

   task automatic test_back_to_back();
      frame_t a;
      frame_t b;
      bit ok;
      int d0;
      do_reset();
      d0 = div_cnt;
      vprob = 100;
      scan_len = 100;
      rand_frame(a);
      rand_frame(b);
      push_frame(a, FW, FW - 1);
      run_until_starts(1, 200, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_first_timeout got %0d starts want 1", starts_seen);
      end
      push_frame(b, FW, FW - 1);
      run_until_drained(200, ok);
      run(2);
      checks++;
      if ({opending, in_ready, orunning} !== 3'b101) begin
         errors++;
         $display("FAIL b2b_queued got pend/rdy/run %b want 101", {opending, in_ready, orunning});
      end
      checks++;
      if (threshold !== thr_of(a) || blockTemplate !== tmpl_of(a)) begin
         errors++;
         $display("FAIL b2b_active_held got %h want %h", threshold, thr_of(a));
      end
      run_until_starts(2, 300, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_second_timeout got %0d starts want 2", starts_seen);
      end
      checks++;
      if (start_edge - idle_edge !== 1) begin
         errors++;
         $display("FAIL b2b_idle_gap got %0d edges want 1", start_edge - idle_edge);
      end
      checks++;
      if (threshold !== thr_of(b) || blockTemplate !== tmpl_of(b)) begin
         errors++;
         $display("FAIL b2b_active_b got %h want %h", threshold, thr_of(b));
      end
      checks++;
      if (olaunches !== 16'd2) begin
         errors++;
         $display("FAIL b2b_launches got %0d want 2", olaunches);
      end
      run(110);
      checks++;
      if (div_cnt !== d0) begin
         errors++;
         $display("FAIL b2b_model got %0d divergences want 0", div_cnt - d0);
      end
   endtask

   task automatic test_early_last();
      frame_t x;
      frame_t c;
      bit ok;
      int d0;
      do_reset();
      d0 = div_cnt;
      vprob = 70;
      scan_len = 5;
      rand_frame(x);
      rand_frame(c);
      push_frame(x, 11, 10);
      run_until_drained(100, ok);
      run(5);
      checks++;
      if (errs_seen !== 1 || starts_seen !== 0 || opending !== 1'b0) begin
         errors++;
         $display("FAIL early_error got err %0d start %0d pend %b want 1 0 0",
                  errs_seen, starts_seen, opending);
      end
      push_frame(c, FW, FW - 1);
      run_until_starts(1, 300, ok);
      checks++;
      if (!ok || threshold !== thr_of(c) || blockTemplate !== tmpl_of(c)) begin
         errors++;
         $display("FAIL early_recover got %h want %h", threshold, thr_of(c));
      end
      run(10);
      checks++;
      if (errs_seen !== 1 || div_cnt !== d0) begin
         errors++;
         $display("FAIL early_model got err %0d div %0d want 1 0", errs_seen, div_cnt - d0);
      end
   endtask

   task automatic test_missing_last();
      frame_t x;
      frame_t d;
      bit ok;
      int d0;
      do_reset();
      d0 = div_cnt;
      vprob = 80;
      scan_len = 5;
      rand_frame(x);
      rand_frame(d);
      push_frame(x, FW, -1);
      run_until_drained(150, ok);
      run(3);
      checks++;
      if (errs_seen !== 1 || starts_seen !== 0) begin
         errors++;
         $display("FAIL missing_error got err %0d start %0d want 1 0", errs_seen, starts_seen);
      end
      push_frame(d, FW, FW - 1);
      run_until_starts(1, 300, ok);
      checks++;
      if (!ok || threshold !== thr_of(d) || blockTemplate !== tmpl_of(d)) begin
         errors++;
         $display("FAIL missing_recover got %h want %h", threshold, thr_of(d));
      end
      checks++;
      if (olaunches !== 16'd1) begin
         errors++;
         $display("FAIL missing_launches got %0d want 1", olaunches);
      end
      run(10);
      checks++;
      if (div_cnt !== d0) begin
         errors++;
         $display("FAIL missing_model got %0d divergences want 0", div_cnt - d0);
      end
   endtask

   task automatic test_backpressure();
      frame_t e;
      frame_t f;
      frame_t g;
      bit ok;
      int d0;
      do_reset();
      d0 = div_cnt;
      vprob = 40;
      scan_len = 60;
      rand_frame(e);
      rand_frame(f);
      rand_frame(g);
      push_frame(e, FW, FW - 1);
      push_frame(f, FW, FW - 1);
      push_frame(g, FW, FW - 1);
      run_until_starts(3, 2000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL bp_timeout got %0d starts want 3", starts_seen);
      end
      checks++;
      if (acc_while_full !== 0 || words_acc !== 3 * FW) begin
         errors++;
         $display("FAIL bp_words got %0d accepted %0d while full want %0d 0",
                  words_acc, acc_while_full, 3 * FW);
      end
      checks++;
      if (threshold !== thr_of(g) || blockTemplate !== tmpl_of(g) || olaunches !== 16'd3) begin
         errors++;
         $display("FAIL bp_active got %h n %0d want %h n 3", threshold, olaunches, thr_of(g));
      end
      run(70);
      checks++;
      if (errs_seen !== 0 || div_cnt !== d0) begin
         errors++;
         $display("FAIL bp_model got err %0d div %0d want 0 0", errs_seen, div_cnt - d0);
      end
   endtask

   task automatic test_reset_mid();
      frame_t a;
      frame_t b;
      frame_t c;
      bit ok;
      int k;
      int d0;
      do_reset();
      d0 = div_cnt;
      vprob = 100;
      scan_len = 8;
      rand_frame(a);
      rand_frame(b);
      rand_frame(c);
      push_frame(a, FW, FW - 1);
      k = 0;
      while (words_acc < 12 && k < 100) begin
         tick();
         k++;
      end
      tx_q.delete();
      rst = 1'b1;
      tick();
      checks++;
      if ({start, oframe_error, opending, orunning, in_ready} !== 5'b0 ||
          olaunches !== 16'd0 || threshold !== 64'd0) begin
         errors++;
         $display("FAIL rst_midframe got flags %b n %0d want 0 0",
                  {start, oframe_error, opending, orunning, in_ready}, olaunches);
      end
      rst = 1'b0;
      clear_obs();
      push_frame(b, FW, FW - 1);
      run_until_starts(1, 200, ok);
      checks++;
      if (!ok || olaunches !== 16'd1 || threshold !== thr_of(b)) begin
         errors++;
         $display("FAIL rst_after_frame got n %0d thr %h want 1 %h", olaunches, threshold, thr_of(b));
      end
      rst = 1'b1;
      tick();
      checks++;
      if ({start, orunning, opending} !== 3'b0 || olaunches !== 16'd0 ||
          threshold !== 64'd0 || blockTemplate !== '0) begin
         errors++;
         $display("FAIL rst_in_ack got start/run/pend %b n %0d want 000 0",
                  {start, orunning, opending}, olaunches);
      end
      rst = 1'b0;
      clear_obs();
      run(12);
      push_frame(c, FW, FW - 1);
      run_until_starts(1, 200, ok);
      checks++;
      if (!ok || olaunches !== 16'd1 || threshold !== thr_of(c) || blockTemplate !== tmpl_of(c)) begin
         errors++;
         $display("FAIL rst_fresh got n %0d thr %h want 1 %h", olaunches, threshold, thr_of(c));
      end
      run(12);
      checks++;
      if (div_cnt !== d0) begin
         errors++;
         $display("FAIL rst_model got %0d divergences want 0", div_cnt - d0);
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_last = 1'b0;
      scanner_ready = 1'b1;
      model_reset();
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_early_last();
      test_missing_last();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/sha3_work_loader.md
Name: sha3_work_loader

Overview:
- Upstream feeder for the SHA3 packed-by-6 scanner.
- Accepts work frames as a 32-bit valid/ready word stream, assembles each into a 64-bit threshold plus a 24-word block template, and double-buffers them.
- Issues a one-cycle start to the scanner whenever it is idle and a complete frame is waiting.
- Active threshold/template registers drive the scanner's threshold and blockTemplate inputs directly and stay stable for the whole scan.

Parameters:
- TEMPLATE_WORDS, 24, template words per frame; the frame is TEMPLATE_WORDS+2 words.
- LAUNCH_CNT_W, 16, width of the launch counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_data  in  32  input word.
- in_last  in  1  marks the final word of a frame.
- in_ready  out  1  loader accepts a word this cycle.
- scanner_ready  in  1  scanner oready.
- start  out  1  one-cycle launch pulse to the scanner.
- threshold  out  64  active threshold.
- blockTemplate  out  32 x TEMPLATE_WORDS  active template.
- oframe_error  out  1  one-cycle pulse when a malformed frame is dropped.
- opending  out  1  shadow buffer holds a complete frame.
- orunning  out  1  launch FSM not IDLE.
- olaunches  out  LAUNCH_CNT_W  count of start pulses; wraps modulo 2^W.

Behaviour:
- Reset: every output is 0; active and shadow registers are cleared; word counter wcnt is 0; both FSMs are in their initial states.
- Handshake: a word transfers when in_valid && in_ready.
- in_ready = !shadow_full. It is a registered state, so it is not combinationally dependent on in_valid.

Frame layout:
- Word 0 = threshold[31:0].
- Word 1 = threshold[63:32].
- Word k (2..TEMPLATE_WORDS+1) = template[k-2].

Fill FSM:
- FILL: each transfer writes the word at wcnt and increments wcnt.
- Transfer at wcnt == TEMPLATE_WORDS+1 with in_last=1: shadow_full<=1 and wcnt<=0.
- Transfer with in_last=1 at any earlier wcnt: discard the partial frame, wcnt<=0, pulse oframe_error next cycle.
- Transfer at the final index with in_last=0: same error handling. That word is consumed, and the next word starts a new frame.
- FULL (shadow_full=1): in_ready=0 and the shadow is held.

Launch FSM:
- IDLE: if shadow_full && scanner_ready, then:
  - copy shadow to active registers;
  - clear shadow_full;
  - start<=1 for exactly one cycle;
  - olaunches increments;
  - go to ACK.
- ACK: wait for scanner_ready==0, then go to RUN. Waiting is unbounded; the scanner contract is that oready drops after start.
- RUN: wait for scanner_ready==1, then go to IDLE. A queued frame launches on the following cycle at the earliest, so there is one idle cycle between scans.
- Simultaneous events: a launch copy and the final-word write in the same cycle cannot collide, because the final word only lands while shadow_full=0 and a launch needs shadow_full=1. in_ready rises the cycle after the copy.
- Active registers change only on a launch copy, so they are never modified while orunning=1.
- Reset mid-operation: rst overrides everything in that cycle, and any partial or queued frame is lost. The scanner itself is not reset by this block.
- opending = shadow_full.
- orunning = (state != IDLE).

Latency:
- Final word accepted at cycle T: shadow_full at T+1. If the FSM is IDLE and scanner_ready=1 at T+1, start and the active registers are valid at T+2.

Decomposition:
- Shared package sha3_scan_pkg holds:
  - constant TEMPLATE_WORDS=24;
  - typedef template_t (array of 24 x 32-bit);
  - localparam frame length;
  - enum launch_state_t {IDLE, ACK, RUN}.
- One sub-module is natural: sha3_frame_assembler (wcnt, shadow registers, in_last/error checking, shadow_full). The loader top holds the launch FSM and active registers, and instantiates ahead of sha3_packed6_scanner.

Test Plan:
- Single frame: 26 words (threshold 0x0000_00FF_FFFF_FFFF, template[i]=i), in_last on word 25, scanner_ready=1 → start pulses once at T+2; threshold and blockTemplate match; olaunches=1.
- Back-to-back: send frame A, then frame B while the scanner holds ready=0 for 100 cycles → B accepted; in_ready=0 after B; active registers still A; B launches one cycle after the IDLE return; olaunches=2.
- Early in_last on word 10 → oframe_error pulses once; no start; the next correct frame launches normally.
- Missing in_last on word 25 → error pulse; the following 26-word frame is accepted intact.
- Backpressure: in_valid toggling randomly, with shadow full and the scanner busy → no word lost or duplicated; in_ready=0 until the launch copy.
- rst asserted mid-frame (word 12) and again in ACK state → all outputs 0 on the next cycle; a fresh frame afterwards launches correctly; olaunches restarts from 0.
